// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_ctrl
// Purpose  : Bit-serial subtractor, DIFF = A - B, one bit per clock, LSB first.
//            Two cascaded half-subtractor cells plus a borrow flop form the
//            per-bit datapath; a 3-state FSM and bit counter sequence it.
// Options  : SERIAL_SUB_CMP_EN adds registered a_lt_b / a_eq_b outputs.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_CMP_EN
  output logic             a_lt_b,
  output logic             a_eq_b,
`endif
  output logic             bout
);

  // Counter must be at least one bit wide even for WIDTH=1
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_CMP_EN
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
`endif

  // Per-bit datapath: first half-subtractor on a0/b0, second on (d1, borrow)
  logic             w_d1, w_bw1, w_bit, w_bw2, w_brw_next;
  logic [WIDTH-1:0] w_diff_shift;

  assign w_d1       = a_q[0] ^ b_q[0];
  assign w_bw1      = ~a_q[0] & b_q[0];
  assign w_bit      = w_d1 ^ brw_q;
  assign w_bw2      = ~w_d1 & brw_q;
  assign w_brw_next = w_bw1 | w_bw2;

  // New difference bit enters at the MSB end; a single-bit result has no tail
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign w_diff_shift = w_bit;
    end else begin : g_shift_wn
      assign w_diff_shift = {w_bit, diff_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_SUB_CMP_EN
    lt_d    = lt_q;
    eq_d    = eq_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
`ifdef SERIAL_SUB_CMP_EN
          lt_d    = 1'b0;
          eq_d    = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        brw_d  = w_brw_next;
        diff_d = w_diff_shift;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == c_LAST) begin
          bout_d  = w_brw_next;
`ifdef SERIAL_SUB_CMP_EN
          lt_d    = w_brw_next;
          eq_d    = (w_diff_shift == '0);
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Operand, result, borrow and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      brw_q  <= 1'b0;
      bout_q <= 1'b0;
      cnt_q  <= '0;
`ifdef SERIAL_SUB_CMP_EN
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      diff_q <= diff_d;
      brw_q  <= brw_d;
      bout_q <= bout_d;
      cnt_q  <= cnt_d;
`ifdef SERIAL_SUB_CMP_EN
      lt_q   <= lt_d;
      eq_q   <= eq_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_CMP_EN
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub_ctrl
// Purpose  : Directed self-checking bench for serial_sub_ctrl (WIDTH=8 and
//            WIDTH=1 instances). SERIAL_SUB_CMP_EN enables compare-output checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

`ifdef SERIAL_SUB_CMP_EN
  logic       a_lt_b, a_eq_b, a_lt_b1, a_eq_b1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUB_CMP_EN
    .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
`endif
    .bout(bout)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1),
`ifdef SERIAL_SUB_CMP_EN
    .a_lt_b(a_lt_b1), .a_eq_b(a_eq_b1),
`endif
    .bout(bout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in RUN right after an accept (pre busy cycles already elapsed);
  // returns with the DONE cycle being sampled.
  task automatic wait_done(input string tag, input int pre, input logic [7:0] ediff,
                           input logic ebout, input logic elt, input logic eeq);
    int nbusy = pre;
    int guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      if (busy === 1'b1) nbusy++;
      tick();
      guard++;
    end
    if (done === 1'b1) done_seen++;
    check({tag, "_done"},   {31'd0, done}, 32'd1);
    check({tag, "_busyN"},  nbusy, 32'd8);
    check({tag, "_busyLo"}, {31'd0, busy}, 32'd0);
    check({tag, "_diff"},   {24'd0, diff}, {24'd0, ediff});
    check({tag, "_bout"},   {31'd0, bout}, {31'd0, ebout});
`ifdef SERIAL_SUB_CMP_EN
    check({tag, "_lt"},     {31'd0, a_lt_b}, {31'd0, elt});
    check({tag, "_eq"},     {31'd0, a_eq_b}, {31'd0, eeq});
`else
    if (elt === 1'bx || eeq === 1'bx) $display("note: unknown compare expectation");
`endif
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 0x5A - 0x3C = 0x1E
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0; a = 8'hAA; b = 8'hFF;
    check("t1_accept", {31'd0, busy}, 32'd1);
    wait_done("t1", 0, 8'h1E, 1'b0, 1'b0, 1'b0);
    tick();
    check("t1_doneLo", {31'd0, done}, 32'd0);
    check("t1_hold",   {24'd0, diff}, 32'h1E);

    // 0x00 - 0x01: full borrow ripple
    a = 8'h00; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_clrDiff", {24'd0, diff}, 32'd0);
    wait_done("t2", 0, 8'hFF, 1'b1, 1'b1, 1'b0);
    tick();

    // Back-to-back with start held high
    done_seen = 0;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    a = 8'h80; b = 8'h00;
    wait_done("t3a", 0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    check("t3_idleBusy", {31'd0, busy}, 32'd0);
    check("t3_idleDone", {31'd0, done}, 32'd0);
    tick();
    check("t3_reaccept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done("t3b", 0, 8'h80, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("t3_nDone", done_seen, 32'd2);

    // Start re-pulsed during RUN is ignored
    a = 8'h10; b = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4", 3, 8'hF0, 1'b1, 1'b1, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("t4_noExtra", done_seen, 32'd0);

    // Asynchronous reset mid-RUN
    a = 8'h55; b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("t5_midDiff", {31'd0, (diff != 8'h00)}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_diff", {24'd0, diff}, 32'd0);
    check("t5_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("t5_noDone", done_seen, 32'd0);
    a = 8'h03; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5", 0, 8'h02, 1'b0, 1'b0, 1'b0);
    tick();

    // WIDTH=1 instance: 0 - 1
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("w1_busy", {31'd0, busy1}, 32'd1);
    check("w1_doneLo", {31'd0, done1}, 32'd0);
    tick();
    check("w1_done", {31'd0, done1}, 32'd1);
    check("w1_busyLo", {31'd0, busy1}, 32'd0);
    check("w1_diff", {31'd0, diff1}, 32'd1);
    check("w1_bout", {31'd0, bout1}, 32'd1);
`ifdef SERIAL_SUB_CMP_EN
    check("w1_lt", {31'd0, a_lt_b1}, 32'd1);
    check("w1_eq", {31'd0, a_eq_b1}, 32'd0);
`endif
    tick();
    check("w1_after", {31'd0, done1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
